// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back output collector.
package wb_pkg;
  localparam int LANES = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } wb_state_t;

  // Lanes-per-word request folded into 1..LANES.
  function automatic logic [CNT_W-1:0] clamp_lanes(input logic [CNT_W-1:0] v);
    if (v == 3'd0)      return 3'd1;
    else if (v > 3'd4)  return 3'd4;
    else                return v;
  endfunction
endpackage

// File: rtl/wb_fifo2.sv
// Two-entry FIFO; a push into a full FIFO lands only when a pop frees the head slot the same cycle.
module wb_fifo2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  logic [1:0][WIDTH-1:0] mem_q;
  logic                  rd_q, wr_q;
  logic [1:0]            cnt_q;
  logic                  do_pop, do_push;

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else if (flush_i) begin
      mem_q <= '0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      // When full, wr_q == rd_q, so a push+pop overwrites the slot being popped.
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= ~wr_q;
      end
      if (do_pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/wb_out_collector.sv
// Packs muxed SMAC lanes into output words, queues them in a 2-entry FIFO and
// writes them to output memory over a valid/ready port.
module wb_out_collector
  import wb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cnt_clear,
  input  logic                    cnt_load,
  input  logic [2:0]              max_val,
  input  logic [ADDR_W-1:0]       num_words,
  input  logic                    act_wb,
  input  logic [SEL_W-1:0]        sel_mux_out,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    wr_ready,
  output logic                    wr_valid,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [LANES*DATA_W-1:0] wr_data,
  output logic                    wb_busy,
  output logic                    wb_done,
  output logic                    err_ovf,
  output logic                    err_seq
);
  wb_state_t                    state_q, state_d;
  logic [CNT_W-1:0]             max_cfg_q, max_cfg_d;
  logic [ADDR_W-1:0]            num_cfg_q, num_cfg_d;
  logic [ADDR_W-1:0]            words_q, words_d;
  logic [ADDR_W-1:0]            addr_q, addr_d;
  logic [SEL_W-1:0]             ptr_q, ptr_d;
  logic [LANES-1:0][DATA_W-1:0] lanes_q, lanes_d, lanes_w, word;
  logic                         err_ovf_q, err_ovf_d, err_seq_q, err_seq_d;
  logic                         load_ok, collecting, accept, last_lane;
  logic                         push, pop, fifo_full, fifo_empty;

  assign load_ok    = cnt_load && (state_q == IDLE);
  assign collecting = (state_q == IDLE) || (state_q == COLLECT);
  assign accept     = !cnt_clear && !load_ok && act_wb && collecting && (num_cfg_q != '0);
  assign last_lane  = ({1'b0, ptr_q} == (max_cfg_q - 3'd1));
  assign push       = accept && last_lane;
  assign pop        = wr_valid && wr_ready && !cnt_clear;

  // Lane file with this cycle's lane merged in, so the word can be pushed on the same edge.
  always_comb begin
    lanes_w = lanes_q;
    if (accept) lanes_w[ptr_q] = data_in;
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign word[g] = (g < int'(max_cfg_q)) ? lanes_w[g] : '0;
  end

  always_comb begin
    state_d   = state_q;
    max_cfg_d = max_cfg_q;
    num_cfg_d = num_cfg_q;
    words_d   = words_q;
    addr_d    = addr_q;
    ptr_d     = ptr_q;
    lanes_d   = lanes_q;
    err_ovf_d = err_ovf_q;
    err_seq_d = err_seq_q;
    if (cnt_clear) begin
      state_d   = IDLE;
      words_d   = '0;
      addr_d    = '0;
      ptr_d     = '0;
      lanes_d   = '0;
      err_ovf_d = 1'b0;
      err_seq_d = 1'b0;
    end else begin
      if (load_ok) begin
        max_cfg_d = clamp_lanes(max_val);
        num_cfg_d = num_words;
      end
      if (accept) begin
        lanes_d = lanes_w;
        if (sel_mux_out != ptr_q) err_seq_d = 1'b1;
        if (last_lane) begin
          lanes_d = '0;
          ptr_d   = '0;
          words_d = words_q + 1'b1;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      if (push && fifo_full && !pop) err_ovf_d = 1'b1;
      if (pop) addr_d = addr_q + 1'b1;
      case (state_q)
        IDLE: if (act_wb && !load_ok) begin
          if (num_cfg_q == '0)                   state_d = DONE;
          else if (push && words_d == num_cfg_q) state_d = DRAIN;
          else                                   state_d = COLLECT;
        end
        COLLECT: if (push && words_d == num_cfg_q) state_d = DRAIN;
        DRAIN:   if (fifo_empty) state_d = DONE;
        DONE: begin
          state_d = IDLE;
          words_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      max_cfg_q <= 3'd4;
      num_cfg_q <= '0;
      words_q   <= '0;
      addr_q    <= '0;
      ptr_q     <= '0;
      lanes_q   <= '0;
      err_ovf_q <= 1'b0;
      err_seq_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      max_cfg_q <= max_cfg_d;
      num_cfg_q <= num_cfg_d;
      words_q   <= words_d;
      addr_q    <= addr_d;
      ptr_q     <= ptr_d;
      lanes_q   <= lanes_d;
      err_ovf_q <= err_ovf_d;
      err_seq_q <= err_seq_d;
    end
  end

  wb_fifo2 #(.WIDTH(LANES*DATA_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (cnt_clear),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (word),
    .dout_o  (wr_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign wr_valid = !fifo_empty;
  assign wr_addr  = addr_q;
  assign wb_busy  = (state_q == COLLECT) || (state_q == DRAIN);
  assign wb_done  = (state_q == DONE);
  assign err_ovf  = err_ovf_q;
  assign err_seq  = err_seq_q;
endmodule
